// File: rtl/idelay_tap_calib.sv
// Input-delay calibration: sweeps the IDELAY tap via the load path, finds the longest
// contiguous passing window against a static q1/q2 training pattern, and loads its centre.
module idelay_tap_calib #(
  parameter int              WIDTH         = 1,
  parameter int              TAP_MAX       = 511,
  parameter int              SETTLE_CYCLES = 16,
  parameter int              SAMPLE_CYCLES = 64,
  parameter int              VTC_CYCLES    = 16,
  parameter logic [WIDTH-1:0] PATTERN_Q1   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PATTERN_Q2   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rdy_idelay,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic             load,
  output logic [8:0]       cnt_value_in,
  output logic             en_vtc,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [8:0]       tap_result,
  output logic [9:0]       window_len
);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, VTC_OFF, LOAD, SETTLE, SAMPLE, EVAL, LOAD_CTR, SETTLE_CTR, VTC_ON
  } state_t;

  localparam logic [8:0]  TAP_LAST    = 9'(TAP_MAX);
  localparam logic [31:0] VTC_LAST    = 32'(VTC_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [8:0]  tap_reg, tap_next;
  logic        pass_reg, pass_next;
  logic [8:0]  cur_start_reg, cur_start_next;
  logic [9:0]  cur_len_reg, cur_len_next;
  logic [8:0]  best_start_reg, best_start_next;
  logic [9:0]  best_len_reg, best_len_next;
  logic [8:0]  centre_reg, centre_next;
  logic        load_reg, load_next;
  logic [8:0]  cnt_value_reg, cnt_value_next;
  logic        en_vtc_reg, en_vtc_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        fail_reg, fail_next;
  logic [8:0]  tap_result_reg, tap_result_next;
  logic [9:0]  window_len_reg, window_len_next;

  // A tap only passes when every lane sees the training pattern on both edges.
  logic [WIDTH-1:0] lane_ok;
  logic             all_ok;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign lane_ok[gi] = (q1[gi] == PATTERN_Q1[gi]) && (q2[gi] == PATTERN_Q2[gi]);
    end
  endgenerate

  assign all_ok = &lane_ok;

  logic [8:0] c_start, b_start;
  logic [9:0] c_len, b_len;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    tap_next        = tap_reg;
    pass_next       = pass_reg;
    cur_start_next  = cur_start_reg;
    cur_len_next    = cur_len_reg;
    best_start_next = best_start_reg;
    best_len_next   = best_len_reg;
    centre_next     = centre_reg;
    load_next       = 1'b0;
    cnt_value_next  = cnt_value_reg;
    en_vtc_next     = en_vtc_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    fail_next       = fail_reg;
    tap_result_next = tap_result_reg;
    window_len_next = window_len_reg;
    c_start         = cur_start_reg;
    c_len           = cur_len_reg;
    b_start         = best_start_reg;
    b_len           = best_len_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = WAIT_RDY;
          busy_next       = 1'b1;
          done_next       = 1'b0;
          fail_next       = 1'b0;
          tap_next        = '0;
          cur_start_next  = '0;
          cur_len_next    = '0;
          best_start_next = '0;
          best_len_next   = '0;
          centre_next     = '0;
          tap_result_next = '0;
          window_len_next = '0;
        end
      end
      WAIT_RDY: begin
        if (rdy_idelay) begin
          en_vtc_next = 1'b0;
          cnt_next    = '0;
          if (VTC_CYCLES == 0) begin
            state_next     = LOAD;
            load_next      = 1'b1;
            cnt_value_next = tap_reg;
          end else begin
            state_next = VTC_OFF;
          end
        end
      end
      VTC_OFF: begin
        if (cnt_reg == VTC_LAST) begin
          state_next     = LOAD;
          load_next      = 1'b1;
          cnt_value_next = tap_reg;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      LOAD: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
          cnt_next   = '0;
          pass_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      SAMPLE: begin
        pass_next = pass_reg & all_ok;
        if (cnt_reg == SAMPLE_LAST) begin
          state_next = EVAL;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      EVAL: begin
        if (pass_reg) begin
          if (c_len == 10'd0) c_start = tap_reg;
          c_len = c_len + 10'd1;
        end else begin
          if (c_len > b_len) begin
            b_start = c_start;
            b_len   = c_len;
          end
          c_len = '0;
        end
        if (tap_reg < TAP_LAST) begin
          tap_next       = tap_reg + 9'd1;
          state_next     = LOAD;
          load_next      = 1'b1;
          cnt_value_next = tap_reg + 9'd1;
        end else begin
          // Close a window still open at the last tap so it competes too.
          if (c_len > b_len) begin
            b_start = c_start;
            b_len   = c_len;
          end
          c_len          = '0;
          centre_next    = b_start + b_len[9:1];
          state_next     = LOAD_CTR;
          load_next      = 1'b1;
          cnt_value_next = b_start + b_len[9:1];
        end
        cur_start_next  = c_start;
        cur_len_next    = c_len;
        best_start_next = b_start;
        best_len_next   = b_len;
      end
      LOAD_CTR: begin
        state_next = SETTLE_CTR;
        cnt_next   = '0;
      end
      SETTLE_CTR: begin
        if (cnt_reg == SETTLE_LAST) begin
          state_next  = VTC_ON;
          en_vtc_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      VTC_ON: begin
        state_next      = IDLE;
        busy_next       = 1'b0;
        tap_result_next = centre_reg;
        window_len_next = best_len_reg;
        done_next       = (best_len_reg != 10'd0);
        fail_next       = (best_len_reg == 10'd0);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      tap_reg        <= '0;
      pass_reg       <= 1'b0;
      cur_start_reg  <= '0;
      cur_len_reg    <= '0;
      best_start_reg <= '0;
      best_len_reg   <= '0;
      centre_reg     <= '0;
      load_reg       <= 1'b0;
      cnt_value_reg  <= '0;
      en_vtc_reg     <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      tap_result_reg <= '0;
      window_len_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      tap_reg        <= tap_next;
      pass_reg       <= pass_next;
      cur_start_reg  <= cur_start_next;
      cur_len_reg    <= cur_len_next;
      best_start_reg <= best_start_next;
      best_len_reg   <= best_len_next;
      centre_reg     <= centre_next;
      load_reg       <= load_next;
      cnt_value_reg  <= cnt_value_next;
      en_vtc_reg     <= en_vtc_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      fail_reg       <= fail_next;
      tap_result_reg <= tap_result_next;
      window_len_reg <= window_len_next;
    end
  end

  assign load         = load_reg;
  assign cnt_value_in = cnt_value_reg;
  assign en_vtc       = en_vtc_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign fail         = fail_reg;
  assign tap_result   = tap_result_reg;
  assign window_len   = window_len_reg;

endmodule

// File: tb/tb_idelay_tap_calib.sv
// Bench for idelay_tap_calib: a tap-aware q1/q2 driver plus a run-length window model.
module tb_idelay_tap_calib;

  localparam int         W   = 2;
  localparam int         TM  = 31;
  localparam int         S   = 4;
  localparam int         SMP = 8;
  localparam int         V   = 4;
  localparam logic [1:0] P1  = 2'b11;
  localparam logic [1:0] P2  = 2'b00;
  localparam int         BUSY_CYCLES = 1 + V + (TM + 1) * (SMP + S + 2) + 1 + S + 1;

  logic         clk = 1'b0;
  logic         rst, start, rdy_idelay;
  logic [W-1:0] q1, q2;
  logic         load, en_vtc, busy, done, fail;
  logic [8:0]   cnt_value_in, tap_result;
  logic [9:0]   window_len;

  idelay_tap_calib #(
    .WIDTH(W), .TAP_MAX(TM), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(SMP), .VTC_CYCLES(V),
    .PATTERN_Q1(P1), .PATTERN_Q2(P2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rdy_idelay(rdy_idelay), .q1(q1), .q2(q2),
    .load(load), .cnt_value_in(cnt_value_in), .en_vtc(en_vtc), .busy(busy), .done(done),
    .fail(fail), .tap_result(tap_result), .window_len(window_len)
  );

  always #5 clk = ~clk;

  // Stimulus configuration, written only by the main sequence.
  bit [31:0] cur_mask   = '0;
  int        glitch_tap = -1;
  bit        bad_lane1  = 1'b0;

  // Monitor/driver state, written only by the negedge process.
  int         load_total = 0, busy_total = 0, vtc_low_total = 0, dbl_total = 0;
  int         since = 1000;
  logic [8:0] drv_tap = '0, last_load = '0;
  logic       prev_load = 1'b0;
  logic [3:0] rnd;
  bit         in_win, good;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_total++;
      last_load = cnt_value_in;
      drv_tap   = cnt_value_in;
      since     = 0;
      if (prev_load === 1'b1) dbl_total++;
    end else begin
      since++;
    end
    prev_load = load;
    if (busy === 1'b1) busy_total++;
    if (en_vtc === 1'b0) vtc_low_total++;

    in_win = (since >= S + 1) && (since <= S + SMP);
    good   = in_win && cur_mask[drv_tap[4:0]] && !(int'(drv_tap) == glitch_tap && since == S + 3);
    rnd    = 4'($urandom_range(1, 15));
    if (in_win && bad_lane1) begin
      q1 = P1 ^ 2'b10;
      q2 = P2;
    end else if (good) begin
      q1 = P1;
      q2 = P2;
    end else if (in_win) begin
      q1 = P1 ^ rnd[3:2];
      q2 = P2 ^ rnd[1:0];
    end else begin
      q1 = rnd[3:2];
      q2 = rnd[1:0];
    end
  end

  int passed = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: enumerate every maximal run of passing taps, keep the first longest.
  function automatic void model(input bit [31:0] m, output int cen, output int len);
    int best_s = 0, best_l = 0;
    for (int s = 0; s <= TM; s++) begin
      if (m[s] && (s == 0 || !m[s-1])) begin
        int l = 0;
        while (s + l <= TM && m[s+l]) l++;
        if (l > best_l) begin
          best_l = l;
          best_s = s;
        end
      end
    end
    len = best_l;
    cen = (best_l > 0) ? best_s + best_l / 2 : 0;
  endfunction

  function automatic bit [31:0] rng(input int lo, input int hi);
    bit [31:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic run(input string tag, input bit [31:0] m, input int g, input bit bl,
                     input int rdy_delay);
    bit [31:0] eff;
    int ecen, elen, lb, bb, db, vb, cyc;
    eff = m;
    if (g >= 0) eff[g] = 1'b0;
    if (bl) eff = '0;
    model(eff, ecen, elen);
    cur_mask   = m;
    glitch_tap = g;
    bad_lane1  = bl;
    rdy_idelay = (rdy_delay == 0);
    @(negedge clk);
    lb = load_total; bb = busy_total; db = dbl_total; vb = vtc_low_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    if (rdy_delay > 0) begin
      repeat (rdy_delay) @(negedge clk);
      check({tag, " loads_before_rdy"}, 32'(load_total - lb), 32'd0);
      check({tag, " en_vtc_before_rdy"}, 32'(vtc_low_total - vb), 32'd0);
      rdy_idelay = 1'b1;
    end
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'(elen > 0));
    check({tag, " fail"}, 32'(fail), 32'(elen == 0));
    check({tag, " tap_result"}, 32'(tap_result), 32'(ecen));
    check({tag, " window_len"}, 32'(window_len), 32'(elen));
    check({tag, " en_vtc"}, 32'(en_vtc), 32'd1);
    check({tag, " load_count"}, 32'(load_total - lb), 32'(TM + 2));
    check({tag, " final_load"}, 32'(last_load), 32'(ecen));
    check({tag, " load_width"}, 32'(dbl_total - db), 32'd0);
    if (rdy_delay == 0)
      check({tag, " busy_cycles"}, 32'(busy_total - bb), 32'(BUSY_CYCLES));
    $display("run %s: mask=%08h glitch=%0d lane1_bad=%0d -> tap_result=%0d window_len=%0d done=%0d fail=%0d",
             tag, m, g, bl, tap_result, window_len, done, fail);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; rdy_idelay = 1'b0;
    repeat (3) @(negedge clk);
    check("rst load", 32'(load), 32'd0);
    check("rst cnt_value_in", 32'(cnt_value_in), 32'd0);
    check("rst en_vtc", 32'(en_vtc), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fail", 32'(fail), 32'd0);
    check("rst tap_result", 32'(tap_result), 32'd0);
    check("rst window_len", 32'(window_len), 32'd0);
    rst = 1'b0;

    run("single", rng(10, 20), -1, 1'b0, 0);
    run("tail", rng(3, 5) | rng(20, 31), -1, 1'b0, 0);
    run("tie", rng(2, 5) | rng(10, 13), -1, 1'b0, 0);
    run("none", 32'h0, -1, 1'b0, 0);
    run("lane1_bad", 32'hffff_ffff, -1, 1'b1, 0);
    run("glitch", rng(10, 20), 15, 1'b0, 0);
    run("rdy_low", rng(10, 20), -1, 1'b0, 50);

    // Reset during the tap-7 load must drop the sweep at once.
    cur_mask = $urandom; glitch_tap = -1; bad_lane1 = 1'b0; rdy_idelay = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(load === 1'b1 && cnt_value_in == 9'd7) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid reached_tap7", 32'(cnt_value_in), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid en_vtc", 32'(en_vtc), 32'd1);
    check("rst_mid load", 32'(load), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    check("rst_mid fail", 32'(fail), 32'd0);
    rst = 1'b0;
    $display("run rst_mid: reset applied during tap 7 load");

    run("post_rst", rng(0, 6), -1, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      run($sformatf("rand%0d", i), $urandom | $urandom, -1, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
